event_pulse_controller: RTL and testbench

- Upstream stage of the two-input event counter. Watches two synchronous input streams, in1 and in2, over a programmable window of cycles.
- Turns each rising edge into a one-cycle count-enable pulse (cnt1/cnt2) for the counter. Issues the counter's clr at the start of each measurement.
- Aborts the measurement when the counter's co toggles (overflow), and reports completion with a done pulse and a sticky ovf flag.

---
 rtl/event_pulse_controller_pkg.sv | 21 ++
 rtl/event_pulse_controller_edge.sv | 43 ++++
 rtl/event_pulse_controller.sv | 165 ++++++++++++++++
 tb/tb_event_pulse_controller.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/event_pulse_controller_pkg.sv
// Shared definitions for the event pulse controller slice.
// Holds the FSM state encoding and the default widths of the window
// down-counter and of the per-channel saturating tallies.
package event_pulse_controller_pkg;

    localparam int WIN_W_DEF = 8;
    localparam int TAL_W_DEF = 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CLEAR = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_CLEAR = ST_CLEAR,
        S_RUN   = ST_RUN,
        S_DONE  = ST_DONE
    } state_t;

endpackage

// File: rtl/event_pulse_controller_edge.sv
// edge_pulse_gen: registered rising-edge detector.
// Ports:
//   clk   - clock
//   rst   - synchronous active-high reset
//   load  - capture d as the previous sample without emitting a pulse
//   en    - detect: pulse <= d & ~previous, previous <= d
//   d     - input stream
//   pulse - registered one-cycle pulse per rising edge seen while enabled
module edge_pulse_gen
    import event_pulse_controller_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    input  logic d,
    output logic pulse
);

    logic d_r;
    logic pulse_r;

    // Previous-sample register and edge pulse; load primes the history so a
    // level already high at load time is not treated as an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            d_r     <= 1'b0;
            pulse_r <= 1'b0;
        end else if (load) begin
            d_r     <= d;
            pulse_r <= 1'b0;
        end else if (en) begin
            d_r     <= d;
            pulse_r <= d & ~d_r;
        end else begin
            d_r     <= d_r;
            pulse_r <= 1'b0;
        end
    end

    assign pulse = pulse_r;

endmodule

// File: rtl/event_pulse_controller.sv
// event_pulse_controller: front end of the two-input event counter.
// Watches in1/in2 over a window of win_len cycles, issuing one-cycle count
// enables (cnt1/cnt2) per rising edge, a clear pulse (clr) at measurement
// start, and done/ovf status. A toggle of the counter's co during the window
// aborts the measurement and sets the sticky ovf flag.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   start, win_len    - measurement request (IDLE only) and window length
//   in1, in2, co      - event streams and counter carry level
//   cnt1, cnt2, clr   - counter controls (registered pulses)
//   busy, done, ovf   - status
//   tally1, tally2    - saturating pulse counts of the current/last run
module event_pulse_controller
    import event_pulse_controller_pkg::*;
#(
    parameter int WIN_W = WIN_W_DEF,
    parameter int TAL_W = TAL_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIN_W-1:0] win_len,
    input  logic             in1,
    input  logic             in2,
    input  logic             co,
    output logic             cnt1,
    output logic             cnt2,
    output logic             clr,
    output logic             busy,
    output logic             done,
    output logic             ovf,
    output logic [TAL_W-1:0] tally1,
    output logic [TAL_W-1:0] tally2
);

    localparam logic [WIN_W-1:0] WIN_ZERO = {WIN_W{1'b0}};
    localparam logic [WIN_W-1:0] WIN_ONE  = {{(WIN_W-1){1'b0}}, 1'b1};
    localparam logic [TAL_W-1:0] TAL_ZERO = {TAL_W{1'b0}};
    localparam logic [TAL_W-1:0] TAL_ONE  = {{(TAL_W-1){1'b0}}, 1'b1};
    localparam logic [TAL_W-1:0] TAL_MAX  = {TAL_W{1'b1}};

    state_t           state_r;
    state_t           state_nxt_s;
    logic [WIN_W-1:0] win_cnt_r;
    logic             co_d_r;
    logic             clr_r;
    logic             busy_r;
    logic             done_r;
    logic             ovf_r;
    logic [TAL_W-1:0] tally1_r;
    logic [TAL_W-1:0] tally2_r;

    logic accept_s;
    logic load_s;
    logic run_s;
    logic co_tog_s;

    assign accept_s = (state_r == S_IDLE) && start;
    assign load_s   = (state_r == S_CLEAR);
    assign run_s    = (state_r == S_RUN);
    assign co_tog_s = co ^ co_d_r;

    // Next-state logic; a co toggle ends RUN ahead of window expiry.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start) state_nxt_s = S_CLEAR;
                else       state_nxt_s = S_IDLE;
            end
            S_CLEAR: begin
                if (win_cnt_r != WIN_ZERO) state_nxt_s = S_RUN;
                else                       state_nxt_s = S_DONE;
            end
            S_RUN: begin
                if (co_tog_s)                  state_nxt_s = S_DONE;
                else if (win_cnt_r == WIN_ONE) state_nxt_s = S_DONE;
                else                           state_nxt_s = S_RUN;
            end
            S_DONE:  state_nxt_s = S_IDLE;
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // State register plus status outputs decoded from the next state, so
    // they are registered yet aligned with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
            clr_r   <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            clr_r   <= (state_nxt_s == S_CLEAR);
            busy_r  <= (state_nxt_s == S_CLEAR) || (state_nxt_s == S_RUN);
            done_r  <= (state_nxt_s == S_DONE);
        end
    end

    // Window down-counter: loaded on accepted start, decremented in RUN.
    always_ff @(posedge clk) begin
        if (rst)           win_cnt_r <= WIN_ZERO;
        else if (accept_s) win_cnt_r <= win_len;
        else if (run_s)    win_cnt_r <= win_cnt_r - WIN_ONE;
        else               win_cnt_r <= win_cnt_r;
    end

    // co history; sampling it at CLEAR exit absorbs the toggle caused by clr.
    always_ff @(posedge clk) begin
        if (rst)                  co_d_r <= 1'b0;
        else if (load_s || run_s) co_d_r <= co;
        else                      co_d_r <= co_d_r;
    end

    // Sticky overflow flag, cleared only by the next accepted start.
    always_ff @(posedge clk) begin
        if (rst)                    ovf_r <= 1'b0;
        else if (accept_s)          ovf_r <= 1'b0;
        else if (run_s && co_tog_s) ovf_r <= 1'b1;
        else                        ovf_r <= ovf_r;
    end

    // Saturating tallies of issued pulses; held in IDLE until the next start.
    always_ff @(posedge clk) begin
        if (rst) begin
            tally1_r <= TAL_ZERO;
            tally2_r <= TAL_ZERO;
        end else if (accept_s) begin
            tally1_r <= TAL_ZERO;
            tally2_r <= TAL_ZERO;
        end else begin
            if (cnt1 && (tally1_r != TAL_MAX)) tally1_r <= tally1_r + TAL_ONE;
            else                               tally1_r <= tally1_r;
            if (cnt2 && (tally2_r != TAL_MAX)) tally2_r <= tally2_r + TAL_ONE;
            else                               tally2_r <= tally2_r;
        end
    end

    edge_pulse_gen u_edge1 (
        .clk   (clk),
        .rst   (rst),
        .load  (load_s),
        .en    (run_s),
        .d     (in1),
        .pulse (cnt1)
    );

    edge_pulse_gen u_edge2 (
        .clk   (clk),
        .rst   (rst),
        .load  (load_s),
        .en    (run_s),
        .d     (in2),
        .pulse (cnt2)
    );

    assign clr    = clr_r;
    assign busy   = busy_r;
    assign done   = done_r;
    assign ovf    = ovf_r;
    assign tally1 = tally1_r;
    assign tally2 = tally2_r;

endmodule

// File: tb/tb_event_pulse_controller.sv
// Bench for event_pulse_controller: two instances (8-bit and 2-bit tallies)
// share the stimulus. Expected values come from a per-measurement timeline
// model: cycle 0 = start accepted, 1 = CLEAR, 2.. = RUN, then DONE.
module tb_event_pulse_controller;

    localparam int MAXC = 48;

    logic       clk = 1'b0;
    logic       rst, start, in1, in2, co;
    logic [7:0] win_len;

    logic       cnt1_a, cnt2_a, clr_a, busy_a, done_a, ovf_a;
    logic [7:0] tally1_a, tally2_a;
    logic       cnt1_b, cnt2_b, clr_b, busy_b, done_b, ovf_b;
    logic [1:0] tally1_b, tally2_b;

    int checks   = 0;
    int failures = 0;
    int prev_n1  = 0;
    int prev_n2  = 0;
    int prev_ovf = 0;
    bit co_lvl   = 1'b0;

    event_pulse_controller #(.WIN_W(8), .TAL_W(8)) dut_a (
        .clk(clk), .rst(rst), .start(start), .win_len(win_len),
        .in1(in1), .in2(in2), .co(co),
        .cnt1(cnt1_a), .cnt2(cnt2_a), .clr(clr_a), .busy(busy_a),
        .done(done_a), .ovf(ovf_a), .tally1(tally1_a), .tally2(tally2_a)
    );

    event_pulse_controller #(.WIN_W(8), .TAL_W(2)) dut_b (
        .clk(clk), .rst(rst), .start(start), .win_len(win_len),
        .in1(in1), .in2(in2), .co(co),
        .cnt1(cnt1_b), .cnt2(cnt2_b), .clr(clr_b), .busy(busy_b),
        .done(done_b), .ovf(ovf_b), .tally1(tally1_b), .tally2(tally2_b)
    );

    always #5 clk = ~clk;

    function automatic int satf(input int n, input int m);
        return (n > m) ? m : n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Compare both instances against one set of expectations; n1/n2 are raw
    // pulse counts, saturated here per instance.
    task automatic chk_all(input string tag, input int e_clr, input int e_busy,
                           input int e_done, input int e_ovf, input int e_c1,
                           input int e_c2, input int n1, input int n2);
        chk({tag, " clr"},     32'(clr_a),    e_clr);
        chk({tag, " busy"},    32'(busy_a),   e_busy);
        chk({tag, " done"},    32'(done_a),   e_done);
        chk({tag, " ovf"},     32'(ovf_a),    e_ovf);
        chk({tag, " cnt1"},    32'(cnt1_a),   e_c1);
        chk({tag, " cnt2"},    32'(cnt2_a),   e_c2);
        chk({tag, " tally1"},  32'(tally1_a), satf(n1, 255));
        chk({tag, " tally2"},  32'(tally2_a), satf(n2, 255));
        chk({tag, " b.clr"},   32'(clr_b),    e_clr);
        chk({tag, " b.busy"},  32'(busy_b),   e_busy);
        chk({tag, " b.done"},  32'(done_b),   e_done);
        chk({tag, " b.ovf"},   32'(ovf_b),    e_ovf);
        chk({tag, " b.cnt1"},  32'(cnt1_b),   e_c1);
        chk({tag, " b.cnt2"},  32'(cnt2_b),   e_c2);
        chk({tag, " b.tally1"}, 32'(tally1_b), satf(n1, 3));
        chk({tag, " b.tally2"}, 32'(tally2_b), satf(n2, 3));
    endtask

    // One measurement. mode: 0 random, 1 in1 alternating, 2 simultaneous
    // rise with in1 held through CLEAR, 3 six in1 edges. cot: cycle from which
    // co is inverted (-1 none). sp: extra start cycle. rst_at: reset cycle.
    task automatic measure(input string name, input int L, input int mode,
                           input int cot, input int sp, input int rst_at);
        bit a1 [MAXC];
        bit a2 [MAXC];
        bit ac [MAXC];
        bit p1 [MAXC];
        bit p2 [MAXC];
        int e_last, n_cyc, n1, n2;
        bit ab;
        for (int c = 0; c < MAXC; c++) begin
            case (mode)
                1: begin a1[c] = (c % 2 == 1); a2[c] = 1'b0; end
                2: begin a1[c] = (c != 3); a2[c] = (c >= 4); end
                3: begin a1[c] = (c % 2 == 1) && (c <= 13); a2[c] = 1'b0; end
                default: begin
                    a1[c] = 1'($urandom_range(0, 1));
                    a2[c] = 1'($urandom_range(0, 1));
                end
            endcase
            ac[c] = (cot >= 0 && c >= cot) ? ~co_lvl : co_lvl;
            p1[c] = 1'b0;
            p2[c] = 1'b0;
        end
        // Last RUN cycle: window end or first co change vs. previous cycle.
        e_last = 1;
        ab     = 1'b0;
        for (int k = 2; k <= L + 1; k++) begin
            e_last = k;
            if (ac[k] != ac[k-1]) begin
                ab = 1'b1;
                break;
            end
        end
        // A rise between cycles k-1 and k (k in RUN) pulses in cycle k+1.
        for (int c = 3; c <= e_last + 1; c++) begin
            p1[c] = a1[c-1] && !a1[c-2];
            p2[c] = a2[c-1] && !a2[c-2];
        end
        n_cyc = (rst_at >= 0) ? rst_at + 2 : e_last + 4;
        n1 = prev_n1;
        n2 = prev_n2;
        for (int c = 0; c < n_cyc; c++) begin
            rst     = (c == rst_at);
            start   = (c == 0) || (c == sp);
            win_len = 8'(L);
            in1     = a1[c];
            in2     = a2[c];
            co      = ac[c];
            @(negedge clk);
            if (c == 1) begin
                n1 = 0;
                n2 = 0;
            end
            if (rst_at >= 0 && c > rst_at)
                chk_all($sformatf("%s c%0d", name, c), 0, 0, 0, 0, 0, 0, 0, 0);
            else
                chk_all($sformatf("%s c%0d", name, c), int'(c == 1),
                        int'(c >= 1 && c <= e_last), int'(c == e_last + 1),
                        (c == 0) ? prev_ovf : int'(ab && c >= e_last + 1),
                        int'(p1[c]), int'(p2[c]), n1, n2);
            n1 += int'(p1[c]);
            n2 += int'(p2[c]);
            @(posedge clk);
            #1;
        end
        rst   = 1'b0;
        start = 1'b0;
        if (rst_at >= 0) begin
            prev_n1  = 0;
            prev_n2  = 0;
            prev_ovf = 0;
        end else begin
            prev_n1  = n1;
            prev_n2  = n2;
            prev_ovf = int'(ab);
        end
        co_lvl = ac[n_cyc-1];
    endtask

    initial begin
        int len;
        rst     = 1'b1;
        start   = 1'b1;
        in1     = 1'b0;
        in2     = 1'b0;
        co      = 1'b0;
        win_len = 8'd8;
        @(posedge clk);
        #1;
        repeat (2) begin
            @(negedge clk);
            chk_all("reset", 0, 0, 0, 0, 0, 0, 0, 0);
            @(posedge clk);
            #1;
        end
        rst   = 1'b0;
        start = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk_all("idle", 0, 0, 0, 0, 0, 0, 0, 0);
            @(posedge clk);
            #1;
        end

        measure("win8",     8, 1, -1, -1, -1);
        measure("simul",    5, 2, -1, -1, -1);
        measure("ovf",     20, 0,  7, -1, -1);
        measure("reovf",    6, 0, -1, -1, -1);
        measure("zero",     0, 0, -1, -1, -1);
        measure("startrun",10, 0, -1,  5, -1);
        measure("six",     20, 3, -1, -1, -1);
        measure("rstmid",  20, 0, -1, -1,  9);
        measure("ovflast",  6, 0,  7, -1, -1);
        measure("coclr",    5, 0,  1, -1, -1);
        measure("win1",     1, 0, -1, -1, -1);
        for (int i = 0; i < 8; i++) begin
            len = $urandom_range(1, 30);
            measure($sformatf("rand%0d", i), len, 0,
                    ($urandom_range(0, 2) == 0) ? $urandom_range(2, len + 2) : -1,
                    -1, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
